ui_timeline_fetcher: RTL and testbench

Responder side of the UI-timeline handshake. The UI runtime owns the entry pointer `addr` and the `sync_ui_time` level. This block fetches the addressed health-bar entry from a word-organised synchronous ROM, unpacks it, and computes the absolute deadline `next_ui_time`. It then asserts `update_ui_time` so the runtime can resynchronise. It sits between the timeline ROM and the runtime, clocked by the calculation clock.

---
 rtl/ui_timeline_fetcher.sv | 212 +++++++++++++++++++++
 tb/tb_ui_timeline_fetcher.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ui_timeline_fetcher.sv
// Purpose: fetches one 3-word timeline entry from a synchronous ROM, unpacks it and computes the absolute deadline.
// Latency: update_ui_time rises 4+ROM_LATENCY cycles after the IDLE cycle that samples sync_ui_time==0.
// Backpressure: level handshake; update_ui_time is held until sync_ui_time==1 is sampled; no new fetch until sync_ui_time returns to 0.
//
// Optional feature macro: UI_TIMELINE_ENTRY_CHECK_EN (adds the sticky entry_error geometry check).
//
// ROM timing: rom_addr is the ROM's address register. rom_data carries the word addressed by rom_addr
// as it stood ROM_LATENCY-1 cycles earlier, so ROM_LATENCY=1 means data follows the address in the same cycle.
//
// Ports:
//   clk                    calculation clock (only clock)
//   reset                  synchronous, active-high
//   addr                   entry index from the runtime, latched when a fetch starts
//   current_time           running time in centiseconds
//   sync_ui_time           runtime level: 0 = request fetch, 1 = synced
//   rom_addr               registered ROM word address {entry, word[1:0]}
//   rom_data               ROM read data
//   update_ui_time         entry loaded, field outputs valid
//   reset_healt_status     entry flag
//   healt_bar_pos_x/_pos_y/_w/_h, healt_bar_sensitivity, wait_time   unpacked entry fields
//   next_ui_time           current_time (in LOAD) + wait_time, saturating
//   is_end                 last-entry marker
//   entry_error            sticky geometry error (0 when the check is not built)
module ui_timeline_fetcher #(
  parameter int ADDR_WIDTH    = 10,
  parameter int MAXIMUM_TIMES = 30,
  parameter int ROM_LATENCY   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [MAXIMUM_TIMES-1:0]   current_time,
  input  logic                       sync_ui_time,
  output logic [ADDR_WIDTH+1:0]      rom_addr,
  input  logic [31:0]                rom_data,
  output logic                       update_ui_time,
  output logic                       reset_healt_status,
  output logic [9:0]                 healt_bar_pos_x,
  output logic [9:0]                 healt_bar_pos_y,
  output logic [9:0]                 healt_bar_w,
  output logic [9:0]                 healt_bar_h,
  output logic [6:0]                 healt_bar_sensitivity,
  output logic [15:0]                wait_time,
  output logic [MAXIMUM_TIMES-1:0]   next_ui_time,
  output logic                       is_end,
  output logic                       entry_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic                     issue_first;
  logic                     issue_next;
  logic                     load_en;
  logic [ROM_LATENCY-1:0]   tag_q;
  logic [ROM_LATENCY-1:0]   tag_push;
  logic                     tag_out;
  logic [1:0]               cap_idx;
  logic                     cap_last;

  // Word buffers keep only the bits that carry fields.
  logic [31:0]              word0_q;
  logic [16:0]              word1_q;   // {h, sensitivity}
  logic [15:0]              word2_q;   // wait_time

  logic [MAXIMUM_TIMES:0]   deadline_sum;

  // A tag bit leaving the shift register marks the cycle its word is on rom_data.
  // Words always return in issue order, so a simple index says which buffer to fill.
  assign tag_out  = tag_q[ROM_LATENCY-1];
  assign cap_last = tag_out && (cap_idx == 2'd2);

  always_comb begin
    tag_push    = '0;
    tag_push[0] = issue_first | issue_next;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    issue_first = 1'b0;
    issue_next  = 1'b0;
    load_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!sync_ui_time) begin
          issue_first = 1'b1;
          state_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue_next = 1'b1;
        // Word 1 is on the bus: this edge issues word 2, the last one.
        if (rom_addr[1:0] == 2'd1) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cap_last) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_en   = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (sync_ui_time) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign update_ui_time = (state == ST_DONE);

  // ---------------- Deadline ----------------
  assign deadline_sum = {1'b0, current_time} + {{(MAXIMUM_TIMES-15){1'b0}}, word2_q};

  // ---------------- Datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr              <= '0;
      tag_q                 <= '0;
      cap_idx               <= 2'd0;
      word0_q               <= '0;
      word1_q               <= '0;
      word2_q               <= '0;
      reset_healt_status    <= 1'b0;
      healt_bar_pos_x       <= '0;
      healt_bar_pos_y       <= '0;
      healt_bar_w           <= '0;
      healt_bar_h           <= '0;
      healt_bar_sensitivity <= '0;
      wait_time             <= '0;
      next_ui_time          <= '0;
      is_end                <= 1'b0;
    end else begin
      // The entry bits of rom_addr double as the latched addr for the whole fetch.
      if (issue_first) begin
        rom_addr <= {addr, 2'd0};
      end else if (issue_next) begin
        rom_addr[1:0] <= rom_addr[1:0] + 2'd1;
      end

      tag_q <= (tag_q << 1) | tag_push;

      if (tag_out) begin
        case (cap_idx)
          2'd0:    word0_q <= rom_data;
          2'd1:    word1_q <= rom_data[31:15];
          default: word2_q <= rom_data[15:0];
        endcase
        cap_idx <= (cap_idx == 2'd2) ? 2'd0 : cap_idx + 2'd1;
      end

      // All fields change on the same edge so the runtime never sees a mixed entry.
      if (load_en) begin
        is_end                <= word0_q[31];
        reset_healt_status    <= word0_q[30];
        healt_bar_pos_x       <= word0_q[29:20];
        healt_bar_pos_y       <= word0_q[19:10];
        healt_bar_w           <= word0_q[9:0];
        healt_bar_h           <= word1_q[16:7];
        healt_bar_sensitivity <= word1_q[6:0];
        wait_time             <= word2_q;
        next_ui_time          <= deadline_sum[MAXIMUM_TIMES] ? {MAXIMUM_TIMES{1'b1}}
                                                             : deadline_sum[MAXIMUM_TIMES-1:0];
      end
    end
  end

  // ---------------- Optional geometry check ----------------
`ifdef UI_TIMELINE_ENTRY_CHECK_EN
  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        geom_bad;

  // Screen is 640x480; a bar must have area and end on-screen.
  assign x_end    = {1'b0, word0_q[29:20]} + {1'b0, word0_q[9:0]};
  assign y_end    = {1'b0, word0_q[19:10]} + {1'b0, word1_q[16:7]};
  assign geom_bad = (word0_q[9:0] == 10'd0) || (word1_q[16:7] == 10'd0) ||
                    (x_end > 11'd639) || (y_end > 11'd479);

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_error <= 1'b0;
    end else if (load_en && geom_bad) begin
      entry_error <= 1'b1;
    end
  end
`else
  assign entry_error = 1'b0;
`endif

endmodule

// File: tb/tb_ui_timeline_fetcher.sv
// Directed bench: two instances (ROM_LATENCY 1 and 3) share stimulus, each with its own ROM model.
module tb_ui_timeline_fetcher;

`ifdef UI_TIMELINE_ENTRY_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  addr;
  logic [29:0] current_time;
  logic        sync_ui_time;

  logic [11:0] rom_addr  [2];
  logic [31:0] rom_data  [2];
  logic        upd       [2];
  logic        rst_hs    [2];
  logic [9:0]  px        [2];
  logic [9:0]  py        [2];
  logic [9:0]  bw        [2];
  logic [9:0]  bh        [2];
  logic [6:0]  sens      [2];
  logic [15:0] wt        [2];
  logic [29:0] nxt       [2];
  logic        end_flag  [2];
  logic        err       [2];

  logic [31:0] mem [0:63];
  logic [11:0] a1_d1, a1_d2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // ROM_LATENCY=1: data follows the registered address directly.
  assign rom_data[0] = mem[rom_addr[0][5:0]];
  // ROM_LATENCY=3: two extra address stages.
  always @(posedge clk) begin
    a1_d1 <= rom_addr[1];
    a1_d2 <= a1_d1;
  end
  assign rom_data[1] = mem[a1_d2[5:0]];

  ui_timeline_fetcher #(.ADDR_WIDTH(10), .MAXIMUM_TIMES(30), .ROM_LATENCY(1)) dut0 (
    .clk(clk), .reset(reset), .addr(addr), .current_time(current_time),
    .sync_ui_time(sync_ui_time), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .update_ui_time(upd[0]), .reset_healt_status(rst_hs[0]),
    .healt_bar_pos_x(px[0]), .healt_bar_pos_y(py[0]), .healt_bar_w(bw[0]), .healt_bar_h(bh[0]),
    .healt_bar_sensitivity(sens[0]), .wait_time(wt[0]), .next_ui_time(nxt[0]),
    .is_end(end_flag[0]), .entry_error(err[0]));

  ui_timeline_fetcher #(.ADDR_WIDTH(10), .MAXIMUM_TIMES(30), .ROM_LATENCY(3)) dut1 (
    .clk(clk), .reset(reset), .addr(addr), .current_time(current_time),
    .sync_ui_time(sync_ui_time), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .update_ui_time(upd[1]), .reset_healt_status(rst_hs[1]),
    .healt_bar_pos_x(px[1]), .healt_bar_pos_y(py[1]), .healt_bar_w(bw[1]), .healt_bar_h(bh[1]),
    .healt_bar_sensitivity(sens[1]), .wait_time(wt[1]), .next_ui_time(nxt[1]),
    .is_end(end_flag[1]), .entry_error(err[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_entry(input int idx, input logic e, input logic r,
                           input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                           input logic [9:0] h, input logic [6:0] s, input logic [15:0] t);
    mem[idx*4]   = {e, r, x, y, w};
    mem[idx*4+1] = {h, s, 15'h7FFF};     // reserved bits set to ones
    mem[idx*4+2] = {16'hFFFF, t};
    mem[idx*4+3] = 32'hDEADBEEF;
  endtask

  task automatic check_fields(input int k, input string tag, input logic e, input logic r,
                              input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                              input logic [9:0] h, input logic [6:0] s, input logic [15:0] t,
                              input logic [29:0] nt);
    string p;
    p = $sformatf("%s_d%0d", tag, k);
    chk({p, "_is_end"}, end_flag[k], e);
    chk({p, "_rst"},    rst_hs[k], r);
    chk({p, "_x"},      px[k], x);
    chk({p, "_y"},      py[k], y);
    chk({p, "_w"},      bw[k], w);
    chk({p, "_h"},      bh[k], h);
    chk({p, "_sens"},   sens[k], s);
    chk({p, "_wait"},   wt[k], t);
    chk({p, "_next"},   nxt[k], nt);
  endtask

  // Requests entry a; measures latency of both DUTs and the DUT0 word address sequence.
  task automatic do_fetch(input logic [9:0] a, input logic [29:0] t, input bit toggle, input string tag);
    int cnt;
    int lat0, lat1;
    logic [11:0] seq [3];
    addr = a;
    current_time = t;
    sync_ui_time = 1'b0;
    lat0 = 0;
    lat1 = 0;
    cnt = 0;
    while ((lat0 == 0 || lat1 == 0) && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt <= 3) seq[cnt-1] = rom_addr[0];
      if (toggle && cnt == 2) addr = a + 10'd5;
      if (upd[0] && lat0 == 0) lat0 = cnt;
      if (upd[1] && lat1 == 0) lat1 = cnt;
    end
    chk({tag, "_lat_L1"}, lat0, 5);
    chk({tag, "_lat_L3"}, lat1, 7);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_rom_addr%0d", tag, i), seq[i], {a, 2'b00} + 12'(i));
    sync_ui_time = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_upd_drop_L1"}, upd[0], 0);
    chk({tag, "_upd_drop_L3"}, upd[1], 0);
    addr = a;
  endtask

  initial begin
    int hi0, hi1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    set_entry(0, 1'b0, 1'b1, 10'd100, 10'd300, 10'd200, 10'd20, 7'd5,   16'd250);
    set_entry(1, 1'b0, 1'b0, 10'd10,  10'd20,  10'd30,  10'd40, 7'd7,   16'd100);
    set_entry(2, 1'b1, 1'b0, 10'd600, 10'd400, 10'd39,  10'd79, 7'd127, 16'd0);
    set_entry(3, 1'b0, 1'b1, 10'd0,   10'd0,   10'd0,   10'd10, 7'd1,   16'd5);
    set_entry(6, 1'b1, 1'b1, 10'd999, 10'd999, 10'd999, 10'd999, 7'd99, 16'd999);

    reset = 1'b1;
    sync_ui_time = 1'b1;
    addr = '0;
    current_time = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_upd",    upd[0], 0);
    chk("rst_addr",   rom_addr[0], 0);
    chk("rst_next",   nxt[0], 0);
    chk("rst_x",      px[0], 0);
    chk("rst_end",    end_flag[0], 0);
    chk("rst_err",    err[0], 0);
    chk("rst_upd_L3", upd[1], 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Entry 0 basic fetch
    do_fetch(10'd0, 30'd1000, 1'b0, "e0");
    for (int k = 0; k < 2; k++)
      check_fields(k, "e0", 1'b0, 1'b1, 10'd100, 10'd300, 10'd200, 10'd20, 7'd5, 16'd250, 30'd1250);
    chk("e0_err", err[0], 0);

    // Entry 1 with addr toggled mid-fetch, deadline saturates
    do_fetch(10'd1, 30'h3FFFFFF6, 1'b1, "e1");
    for (int k = 0; k < 2; k++)
      check_fields(k, "e1", 1'b0, 1'b0, 10'd10, 10'd20, 10'd30, 10'd40, 7'd7, 16'd100, 30'h3FFFFFFF);

    // Entry 2: is_end, wait 0, geometry exactly on the screen edge
    do_fetch(10'd2, 30'd777, 1'b0, "e2");
    for (int k = 0; k < 2; k++)
      check_fields(k, "e2", 1'b1, 1'b0, 10'd600, 10'd400, 10'd39, 10'd79, 7'd127, 16'd0, 30'd777);
    chk("e2_err_edge", err[0], 0);

    // Reset while both instances are in WAIT
    addr = 10'd0;
    current_time = 30'd10;
    sync_ui_time = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    sync_ui_time = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_upd",  upd[0], 0);
    chk("mid_rst_addr", rom_addr[0], 0);
    chk("mid_rst_x",    px[0], 0);
    chk("mid_rst_end",  end_flag[0], 0);
    chk("mid_rst_next", nxt[1], 0);
    reset = 1'b0;
    hi0 = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (upd[0] || upd[1]) hi0++;
    end
    chk("mid_rst_no_upd", hi0, 0);
    do_fetch(10'd1, 30'd50, 1'b0, "post_rst");
    for (int k = 0; k < 2; k++)
      check_fields(k, "post_rst", 1'b0, 1'b0, 10'd10, 10'd20, 10'd30, 10'd40, 7'd7, 16'd100, 30'd150);

    // Zero-width entry: loaded unchanged, error flagged only when the check is built
    do_fetch(10'd3, 30'd0, 1'b0, "e3");
    check_fields(0, "e3", 1'b0, 1'b1, 10'd0, 10'd0, 10'd0, 10'd10, 7'd1, 16'd5, 30'd5);
    chk("e3_err_L1", err[0], EXP_ERR);
    chk("e3_err_L3", err[1], EXP_ERR);
    do_fetch(10'd0, 30'd1000, 1'b0, "sticky");
    chk("sticky_err", err[0], EXP_ERR);

    // sync_ui_time raised mid-fetch: update pulses exactly one cycle
    addr = 10'd0;
    current_time = 30'd5;
    sync_ui_time = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    sync_ui_time = 1'b1;
    hi0 = 0;
    hi1 = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (upd[0]) hi0++;
      if (upd[1]) hi1++;
    end
    chk("viol_pulse_L1", hi0, 1);
    chk("viol_pulse_L3", hi1, 1);
    chk("viol_next", nxt[0], 30'd255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
